// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: capture run sequencer, trigger config register, buffer port mux.
// Optional feature macro SCOPE_PREFILL_EN: hold off triggers until the buffer history is full.
module scope_capture_ctrl #(
    parameter int NSIG = 1,
    parameter int AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        din,
    input  logic              dlatch,
    output logic [7:0]        dout,
    input  logic [NSIG-1:0]   sigout,
    input  logic              triggered,
    output logic [3*NSIG-1:0] conf,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [NSIG-1:0]   mem_wdata,
    input  logic [NSIG-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = 3 * NSIG;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [CW-1:0]   conf_q;
    logic [AW-1:0]   post;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic            rbmode;
    logic [7:0]      dout_q;
    logic [7:0]      rd8;
    logic [CW+2:0]   conf_sh;
    logic [AW+5:0]   post_sh;

    logic is_ctl;
    logic c_arm;
    logic c_abort;
    logic c_rrst;
    logic c_rnext;
    logic c_post;
    logic c_conf;
    logic capturing;
    logic trig_ok;

    assign is_ctl  = dlatch && (din[7:6] == 2'b00);
    assign c_arm   = is_ctl && (din[5:0] == 6'h00);
    assign c_abort = is_ctl && (din[5:0] == 6'h01);
    assign c_rrst  = is_ctl && (din[5:0] == 6'h02);
    assign c_rnext = is_ctl && (din[5:0] == 6'h03);
    assign c_post  = dlatch && (din[7:6] == 2'b01);
    assign c_conf  = dlatch && (din[7:6] == 2'b10);

    assign capturing = (state == S_ARM) || (state == S_RUN);
    assign conf_sh   = {conf_q, din[2:0]};
    assign post_sh   = {post, din[5:0]};

`ifdef SCOPE_PREFILL_EN
    logic [AW-1:0] fill;

    // ~post == 2^AW-1-post: pre-trigger samples needed for a full history
    assign trig_ok = triggered && (fill >= ~post);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (c_arm) begin
            fill <= '0;
        end else if ((state == S_ARM) && (fill != '1)) begin
            fill <= fill + 1'b1;
        end
    end
`else
    assign trig_ok = triggered;
`endif

    // host commands override the capture sequence in the same cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            S_ARM: begin
                if (trig_ok) begin
                    state_nx = (post == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == AW'(1)) begin
                    state_nx = S_DONE;
                end
            end
            default: ;
        endcase
        if (c_arm) begin
            state_nx = S_ARM;
        end else if (c_abort) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_ARM) && trig_ok) begin
                cnt <= post;
            end else if (state == S_RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr <= '0;
        end else if (c_arm) begin
            waddr <= '0;
        end else if (capturing) begin
            waddr <= waddr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr  <= '0;
            rbmode <= 1'b0;
        end else begin
            unique case (1'b1)
                c_arm, c_abort: rbmode <= 1'b0;
                c_rrst: begin
                    if (!capturing) begin
                        raddr  <= waddr;
                        rbmode <= 1'b1;
                    end
                end
                c_rnext: begin
                    if (!capturing && rbmode) begin
                        raddr <= raddr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_q <= '0;
            post   <= '0;
        end else if (!capturing) begin
            if (c_conf) begin
                conf_q <= conf_sh[CW-1:0];
            end
            if (c_post) begin
                post <= post_sh[AW-1:0];
            end
        end
    end

    always_comb begin
        rd8 = '0;
        rd8[NSIG-1:0] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rbmode) begin
            dout_q <= rd8;
        end else begin
            dout_q <= {6'b0, state};
        end
    end

    assign dout      = dout_q;
    assign conf      = conf_q;
    assign mem_we    = capturing;
    assign mem_addr  = capturing ? waddr : raddr;
    assign mem_wdata = sigout;

endmodule
